ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
- Two-master AHB-lite arbiter placed between the RISC-V bus interface (master 0) and a second bus master (master 1, the AI/DMA engine) in front of the shared slave fabric.
- Grants the address phase to one master at a time and muxes its address/control onto the shared bus.
- Tracks the data-phase owner and steers HWDATA from that owner.
- Round-robin arbitration, bounded hold, parks on a default master.

Parameters:
- DEFAULT_MASTER, 0, master granted at reset and when no requests are pending (0 or 1).
- MAX_HOLD, 4, maximum consecutive NONSEQ beats one master may issue while the other requests (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- HBUSREQ0 / HBUSREQ1  in  1  bus request from master 0 / 1.
- HGRANT0 / HGRANT1  out  1  address-phase grant; exactly one high at all times.
- HADDR0 / HADDR1  in  32  address from master 0 / 1.
- HTRANS0 / HTRANS1  in  2  transfer type (IDLE=00, NONSEQ=10; others treated as NONSEQ if bit1 set).
- HSIZE0 / HSIZE1  in  3  transfer size.
- HWRITE0 / HWRITE1  in  1  write flag.
- HWDATA0 / HWDATA1  in  32  write data.
- HADDR  out  32  shared address.
- HTRANS  out  2  shared transfer type.
- HSIZE  out  3  shared size.
- HWRITE  out  1  shared write flag.
- HWDATA  out  32  shared write data (data-phase owner).
- HREADY  in  1  shared slave ready; also fanned out unchanged to both masters by top-level wiring.
- HMASTER  out  1  current address-phase owner (debug/slave use).

Behaviour:
- Registers:
  - grant_owner (1b)
  - dp_owner (1b)
  - dp_valid (1b)
  - hold_cnt (4b)
- Reset, synchronous, while reset=1 at the clock edge:
  - grant_owner=DEFAULT_MASTER, dp_owner=DEFAULT_MASTER, dp_valid=0, hold_cnt=0.
- Combinational outputs:
  - HGRANTx = (grant_owner==x); HMASTER = grant_owner.
  - HADDR/HSIZE/HWRITE = granted master's inputs.
  - HTRANS = granted master's HTRANS, except forced to 00 when reset=1 or the granted master's HBUSREQ=0.
- Data phase:
  - On an edge with HREADY=1: dp_valid <= HTRANS[1]; dp_owner <= grant_owner.
  - HREADY=0 freezes dp_owner, dp_valid, grant_owner and hold_cnt.
  - HWDATA = HWDATAx of dp_owner, regardless of dp_valid.
- Arbitration: evaluated only on edges with HREADY=1.
  - Neither request: grant_owner <= DEFAULT_MASTER, hold_cnt <= 0.
  - Only one master requests: grant_owner <= that master.
  - Both request, owner's HTRANS[1]=1 and hold_cnt < MAX_HOLD-1: keep owner, hold_cnt++.
  - Both request, otherwise: grant_owner <= other master, hold_cnt <= 0.
  - hold_cnt is cleared on every ownership change and whenever the owner issues IDLE.
- Handover latency:
  - New grant is visible the cycle after the deciding edge.
  - Granted master drives its address phase in that cycle.
  - The previous owner's last transfer completes its data phase in parallel (normal AHB pipelining).
- Boundary conditions:
  - Grant never changes while HREADY=0, even if requests drop.
  - Requester deasserts the same cycle it is granted: that cycle's HTRANS is forced IDLE, and it is re-arbitrated on the next HREADY=1 edge.
  - Simultaneous first requests from idle park: the parked master (DEFAULT_MASTER) keeps the grant.
  - Reset asserted mid-transfer: all state returns to reset values next edge; no data-phase recovery.
- No SPLIT/RETRY/HLOCK support; slaves return OKAY only.

Test Plan:
1. Reset held 2 cycles, no requests -> HGRANT0=1, HGRANT1=0, HTRANS=00, HMASTER=0.
2. Only HBUSREQ1=1, M1 writes 0xDEADBEEF to 0x2000_0010, HREADY=1 -> HGRANT1=1 one cycle after the request. Next cycle HADDR=0x20000010, HTRANS=10, HWRITE=1. Cycle after that HWDATA=0xDEADBEEF.
3. Both masters request continuously with back-to-back NONSEQ, MAX_HOLD=4, start owner 0 -> grant alternates: 4 M0 beats, then 4 M1 beats, repeating.
4. M0 owns, slave holds HREADY=0 for 3 cycles, then M1 raises its request -> grant, dp_owner and HWDATA stay on M0 through the stall. Grant moves to M1 only on the first HREADY=1 edge.
5. M0 write in data phase while M1 is granted its address phase (handover) -> HWDATA=HWDATA0 and HADDR=HADDR1 in the same cycle.
6. Reset pulsed while M1 owns with dp_valid=1 -> next cycle HGRANT0=1, HTRANS=00; M1 is re-granted only after reset deasserts and it requests again.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two-master AHB-lite arbiter with round-robin, bounded hold and default-master parking.
module ahb_master_arbiter #(
  parameter logic DEFAULT_MASTER = 1'b0,
  parameter int   MAX_HOLD       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HBUSREQ0,
  input  logic        HBUSREQ1,
  output logic        HGRANT0,
  output logic        HGRANT1,
  input  logic [31:0] HADDR0,
  input  logic [31:0] HADDR1,
  input  logic [1:0]  HTRANS0,
  input  logic [1:0]  HTRANS1,
  input  logic [2:0]  HSIZE0,
  input  logic [2:0]  HSIZE1,
  input  logic        HWRITE0,
  input  logic        HWRITE1,
  input  logic [31:0] HWDATA0,
  input  logic [31:0] HWDATA1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HMASTER
);
  logic       grant_owner, dp_owner, dp_valid, next_owner;
  logic [3:0] hold_cnt, next_hold;
  always_comb begin
    HGRANT0 = !grant_owner;
    HGRANT1 = grant_owner;
    HMASTER = grant_owner;
    HADDR   = grant_owner ? HADDR1 : HADDR0;
    HSIZE   = grant_owner ? HSIZE1 : HSIZE0;
    HWRITE  = grant_owner ? HWRITE1 : HWRITE0;
    HTRANS  = (reset || !(grant_owner ? HBUSREQ1 : HBUSREQ0)) ? 2'b00 : (grant_owner ? HTRANS1 : HTRANS0);
    HWDATA  = dp_owner ? HWDATA1 : HWDATA0;
  end
  // Lone requester takes the bus; contention rotates once the owner idles or exhausts its hold budget.
  always_comb begin
    next_owner = grant_owner;
    next_hold  = hold_cnt;
    if (!HBUSREQ0 && !HBUSREQ1) begin
      next_owner = DEFAULT_MASTER;
      next_hold  = '0;
    end else if (HBUSREQ0 != HBUSREQ1) begin
      next_owner = HBUSREQ1;
      next_hold  = (HBUSREQ1 != grant_owner || !HTRANS[1]) ? '0 : hold_cnt;
    end else if (HTRANS[1] && hold_cnt < 4'(MAX_HOLD - 1)) begin
      next_hold  = hold_cnt + 4'd1;
    end else begin
      next_owner = !grant_owner;
      next_hold  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_owner <= DEFAULT_MASTER;
      dp_owner    <= DEFAULT_MASTER;
      dp_valid    <= 1'b0;
      hold_cnt    <= '0;
    end else if (HREADY) begin
      dp_valid    <= HTRANS[1];
      dp_owner    <= grant_owner;
      grant_owner <= next_owner;
      hold_cnt    <= next_hold;
    end
  end
  // Slaves answer an idle data phase with zero wait states, so a stall implies a live transfer.
  a_stall_needs_transfer: assert property (@(posedge clk) disable iff (reset) !HREADY |-> dp_valid);
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_ahb_master_arbiter;
  localparam int MAX_HOLD = 4;
  logic        clk = 1'b0;
  logic        reset;
  logic        HBUSREQ0, HBUSREQ1, HGRANT0, HGRANT1;
  logic [31:0] HADDR0, HADDR1, HWDATA0, HWDATA1, HADDR, HWDATA;
  logic [1:0]  HTRANS0, HTRANS1, HTRANS;
  logic [2:0]  HSIZE0, HSIZE1, HSIZE;
  logic        HWRITE0, HWRITE1, HWRITE, HREADY, HMASTER;
  int pass_n = 0, total_n = 0;
  bit mo, dpo, dpv;
  int beats;
  always #5 clk = ~clk;
  ahb_master_arbiter #(.DEFAULT_MASTER(1'b0), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1), .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
    .HADDR0(HADDR0), .HADDR1(HADDR1), .HTRANS0(HTRANS0), .HTRANS1(HTRANS1),
    .HSIZE0(HSIZE0), .HSIZE1(HSIZE1), .HWRITE0(HWRITE0), .HWRITE1(HWRITE1),
    .HWDATA0(HWDATA0), .HWDATA1(HWDATA1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HMASTER(HMASTER)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [1:0] exp_trans();
    logic rq = mo ? HBUSREQ1 : HBUSREQ0;
    return (reset || !rq) ? 2'b00 : (mo ? HTRANS1 : HTRANS0);
  endfunction
  task automatic check_outputs();
    chk("grant0", {31'd0, HGRANT0}, {31'd0, mo == 1'b0});
    chk("grant1", {31'd0, HGRANT1}, {31'd0, mo == 1'b1});
    chk("hmaster", {31'd0, HMASTER}, {31'd0, mo});
    chk("haddr", HADDR, mo ? HADDR1 : HADDR0);
    chk("hsize", {29'd0, HSIZE}, {29'd0, mo ? HSIZE1 : HSIZE0});
    chk("hwrite", {31'd0, HWRITE}, {31'd0, mo ? HWRITE1 : HWRITE0});
    chk("htrans", {30'd0, HTRANS}, {30'd0, exp_trans()});
    chk("hwdata", HWDATA, dpo ? HWDATA1 : HWDATA0);
  endtask
  // Reference: the owner may issue up to MAX_HOLD back-to-back NONSEQ beats while contended.
  task automatic model_edge();
    logic [1:0] t = exp_trans();
    bit own_ns = t[1];
    if (reset) begin
      mo = 1'b0; dpo = 1'b0; dpv = 1'b0; beats = 0;
    end else if (HREADY) begin
      dpv = own_ns;
      dpo = mo;
      if (!HBUSREQ0 && !HBUSREQ1) begin
        mo = 1'b0; beats = 0;
      end else if (HBUSREQ0 != HBUSREQ1) begin
        if (HBUSREQ1 != mo || !own_ns) beats = 0;
        mo = HBUSREQ1;
      end else if (own_ns && beats + 1 < MAX_HOLD) begin
        beats++;
      end else begin
        mo = !mo; beats = 0;
      end
    end
  endtask
  task automatic cycle(input bit r, input bit q0, input bit q1, input bit [1:0] t0, input bit [1:0] t1, input bit rdy);
    @(negedge clk);
    reset = r; HBUSREQ0 = q0; HBUSREQ1 = q1; HTRANS0 = t0; HTRANS1 = t1; HREADY = rdy;
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    #2;
  endtask
  initial begin
    reset = 1'b1; HBUSREQ0 = 0; HBUSREQ1 = 0; HTRANS0 = 0; HTRANS1 = 0; HREADY = 1;
    HADDR0 = 32'h1000_0000; HADDR1 = 32'h2000_0010; HSIZE0 = 3'd2; HSIZE1 = 3'd1;
    HWRITE0 = 1; HWRITE1 = 1; HWDATA0 = 32'h0000_A5A5; HWDATA1 = 32'hDEAD_BEEF;
    mo = 0; dpo = 0; dpv = 0; beats = 0;
    cycle(1, 0, 0, 2'b00, 2'b00, 1);
    cycle(1, 0, 0, 2'b00, 2'b00, 1);
    chk("t1_grant0", {31'd0, HGRANT0}, 32'd1);
    chk("t1_htrans", {30'd0, HTRANS}, 32'd0);
    cycle(0, 0, 1, 2'b00, 2'b10, 1);
    chk("t2_grant1", {31'd0, HGRANT1}, 32'd1);
    chk("t2_haddr", HADDR, 32'h2000_0010);
    chk("t2_htrans", {30'd0, HTRANS}, 32'd2);
    chk("t2_hwrite", {31'd0, HWRITE}, 32'd1);
    cycle(0, 0, 1, 2'b00, 2'b10, 1);
    chk("t2_hwdata", HWDATA, 32'hDEAD_BEEF);
    cycle(1, 0, 0, 2'b00, 2'b00, 1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 1, 2'b10, 2'b10, 1);
      chk("t3_rr", {31'd0, HMASTER}, 32'(((i + 1) / 4) % 2));
    end
    cycle(1, 0, 0, 2'b00, 2'b00, 1);
    cycle(0, 1, 0, 2'b10, 2'b00, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, i == 0, 1, 2'b10, 2'b10, 0);
      chk("t4_grant_stall", {31'd0, HMASTER}, 32'd0);
      chk("t4_hwdata_stall", HWDATA, 32'h0000_A5A5);
    end
    cycle(0, 0, 1, 2'b00, 2'b10, 1);
    chk("t4_grant_moved", {31'd0, HMASTER}, 32'd1);
    chk("t5_hwdata_m0", HWDATA, 32'h0000_A5A5);
    chk("t5_haddr_m1", HADDR, 32'h2000_0010);
    cycle(0, 0, 1, 2'b00, 2'b10, 1);
    cycle(1, 0, 1, 2'b00, 2'b10, 1);
    chk("t6_grant0", {31'd0, HGRANT0}, 32'd1);
    chk("t6_htrans", {30'd0, HTRANS}, 32'd0);
    cycle(0, 0, 0, 2'b00, 2'b00, 1);
    chk("t6_still_m0", {31'd0, HGRANT0}, 32'd1);
    cycle(0, 0, 1, 2'b00, 2'b10, 1);
    chk("t6_regrant", {31'd0, HGRANT1}, 32'd1);
    for (int i = 0; i < 2000; i++) begin
      HADDR0 = $urandom; HADDR1 = $urandom; HWDATA0 = $urandom; HWDATA1 = $urandom;
      HSIZE0 = 3'($urandom); HSIZE1 = 3'($urandom);
      HWRITE0 = 1'($urandom); HWRITE1 = 1'($urandom);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            2'($urandom), 2'($urandom), !dpv || $urandom_range(0, 3) != 0);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
